antirebote_multi: RTL
=====================

Name: antirebote_multi

Overview:
- Parametrised, multi-channel successor to the single-button debouncer.
- Debounces N_CH independent push-button inputs with separate press and release filter lengths and optional input inversion.
- Per channel, produces a clean level, one-cycle press and release pulses, and a one-cycle long-press pulse.
- Sits between board push-button pins and the control FSMs, which consume pulses rather than levels.

Parameters:
- N_CH, 4: number of independent button channels (≥1).
- COUNT_PRESS, 50000: consecutive stable cycles required to accept a 0→1 transition (≥2).
- COUNT_RELEASE, 501: consecutive stable cycles required to accept a 1→0 transition (≥2).
- COUNT_LONG, 50000000: cycles the debounced level must stay 1 before long_pulse fires (> COUNT_PRESS).
- ACTIVE_LOW, 1'b1: 1 = the pin reads 0 when pressed; the input is inverted before filtering.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- boton_in  in  N_CH  raw asynchronous button pins.
- boton_out  out  N_CH  debounced level, 1 = pressed.
- press_pulse  out  N_CH  one-cycle strobe when boton_out rises.
- release_pulse  out  N_CH  one-cycle strobe when boton_out falls.
- long_pulse  out  N_CH  one-cycle strobe when a press has lasted COUNT_LONG cycles.

Behaviour:
- Reset:
  - Asserting reset (0) asynchronously clears all outputs, synchronizer flops and counters to 0.
  - Each channel reads "released" after reset, regardless of pin level.
  - Deassertion takes effect at the next clk edge.
  - Reset mid-count discards all progress; no pulse is emitted for an interrupted transition.
- Input path, per channel: p = boton_in ^ ACTIVE_LOW, then a 2-flop synchronizer gives s. The synchronizer resets to 0.
- Filter, per channel, with stable level q = boton_out and counter c:
  - If s == q: c ← 0.
  - If s != q: the threshold is T = COUNT_PRESS when q = 0, or T = COUNT_RELEASE when q = 1.
    - If c == T−1: q ← s and c ← 0.
    - Otherwise: c ← c+1.
  - Result: q flips on the T-th consecutive mismatching sample.
  - A single matching sample restarts the count (glitch rejection).
  - Counter width is $clog2(max(COUNT_PRESS, COUNT_RELEASE)). c never exceeds T−1, so no wrap-around.
- Latency: a clean pin step appears on boton_out 2+T clk edges after the first edge that samples it.
- Pulses, registered:
  - press_pulse is 1 exactly in the cycle where boton_out first reads 1.
  - release_pulse is 1 exactly in the cycle where boton_out first reads 0.
  - Each is asserted for one cycle per transition. They are never both 1 on one channel in the same cycle.
- Long press, per channel, with hold counter h (width $clog2(COUNT_LONG+1)):
  - While boton_out == 1, h increments and saturates at COUNT_LONG.
  - When boton_out == 0, h ← 0.
  - long_pulse is 1 for the single cycle in which h transitions to COUNT_LONG. It fires at most once per press.
  - Release before saturation: no long_pulse.
  - Release in the same cycle as saturation is impossible: h only advances while boton_out is already 1.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.

Decomposition:
- Package antirebote_pkg:
  - Function for the max of two integers, used for counter widths.
  - Default constants CNT_1MS = 50000 and CNT_1S = 50000000 for the 50 MHz board clock.
- Sub-module antirebote_canal holds one channel: synchronizer, filter, pulse and long-press logic. It is scalar I/O and takes all four count and polarity parameters.
- antirebote_multi is a generate loop of N_CH instances.

Test Plan:
All cases use N_CH=2, COUNT_PRESS=8, COUNT_RELEASE=4, COUNT_LONG=20, ACTIVE_LOW=1.
1. Reset held with pins = 2'b00 (both pressed) → all outputs 0. After release of reset, ch0 boton_out rises on edge 2+8 = 10, with press_pulse high that cycle only.
2. ch0 pin pressed, with a 1-cycle high glitch at cycle 5 → no rise at cycle 10. Rise occurs 8 cycles after the glitch clears the synchronizer.
3. Pressed ch0 released cleanly → boton_out falls 6 cycles later, with a single release_pulse. Bounce of 3-cycle chunks → no fall until a 4-cycle stable run.
4. ch1 held pressed → long_pulse once, 20 cycles after boton_out rose, then stays 0 while held. Release at 15 cycles held → no long_pulse.
5. Both channels pressed on the same edge → press_pulse = 2'b11 in one cycle. Reset asserted mid-hold → outputs drop asynchronously to 0, with no release_pulse.

Source files
------------

// File: rtl/antirebote_pkg.sv
// Shared constants and helpers for the multi-channel push-button debouncer.
package antirebote_pkg;

    localparam int CNT_1MS = 50000;
    localparam int CNT_1S  = 50000000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/antirebote_canal.sv
// One debounced button channel: 2-flop synchronizer, asymmetric stability filter,
// press/release strobes and a one-shot long-press strobe.
module antirebote_canal
    import antirebote_pkg::*;
#(
    parameter int COUNT_PRESS   = CNT_1MS,
    parameter int COUNT_RELEASE = 501,
    parameter int COUNT_LONG    = CNT_1S,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic boton_in,
    output logic boton_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int CW = $clog2(max_int(COUNT_PRESS, COUNT_RELEASE));
    localparam int HW = $clog2(COUNT_LONG + 1);

    localparam logic [CW-1:0] PRESS_LAST   = CW'(COUNT_PRESS - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'(COUNT_RELEASE - 1);
    localparam logic [HW-1:0] HOLD_MAX     = HW'(COUNT_LONG);
    localparam logic [HW-1:0] HOLD_LAST    = HW'(COUNT_LONG - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold;
    logic          cnt_last;
    logic          flip;

    // The threshold depends on which way the level is trying to move.
    always_comb begin
        cnt_last = 1'b0;
        if (boton_out) begin
            cnt_last = (cnt == RELEASE_LAST);
        end else begin
            cnt_last = (cnt == PRESS_LAST);
        end
        flip = (sync_p1 != boton_out) && cnt_last;
    end

    // Stage p0/p1: bring the polarity-corrected pin into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= boton_in ^ ACTIVE_LOW;
            sync_p1 <= sync_p0;
        end
    end

    // Filter stage: any matching sample restarts the run of mismatches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            boton_out     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= flip && sync_p1;
            release_pulse <= flip && !sync_p1;
            if (sync_p1 == boton_out) begin
                cnt <= '0;
            end else if (cnt_last) begin
                boton_out <= sync_p1;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Hold stage: saturating counter makes long_pulse a one-shot per press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold       <= '0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= boton_out && (hold == HOLD_LAST);
            if (!boton_out) begin
                hold <= '0;
            end else if (hold != HOLD_MAX) begin
                hold <= hold + HW'(1);
            end
        end
    end

endmodule

// File: rtl/antirebote_multi.sv
// N_CH independent debounced push-button channels for the board's control FSMs.
module antirebote_multi
    import antirebote_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int COUNT_PRESS   = CNT_1MS,
    parameter int COUNT_RELEASE = 501,
    parameter int COUNT_LONG    = CNT_1S,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] boton_in,
    output logic [N_CH-1:0] boton_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse
);

    for (genvar g = 0; g < N_CH; g++) begin : g_canal
        antirebote_canal #(
            .COUNT_PRESS   (COUNT_PRESS),
            .COUNT_RELEASE (COUNT_RELEASE),
            .COUNT_LONG    (COUNT_LONG),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_canal (
            .clk           (clk),
            .reset         (reset),
            .boton_in      (boton_in[g]),
            .boton_out     (boton_out[g]),
            .press_pulse   (press_pulse[g]),
            .release_pulse (release_pulse[g]),
            .long_pulse    (long_pulse[g])
        );
    end

endmodule
